// File: rtl/anim_sched.sv
// anim_sched: mode/enable sequencer for the LED animation mux.
// Auto-cycles patterns with dwell and blank gap; manual override and skip.
module anim_sched #(
    parameter int PRESC  = 4,
    parameter int DWELL  = 3,
    parameter int GAP    = 2,
    parameter int NMODES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       manual,
    input  logic [1:0] sel,
    input  logic       next,
    output logic [1:0] mode,
    output logic       en,
    output logic       tick,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, PLAY, BLANK, MAN} state_t;

    localparam int PW   = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int CMAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [PW-1:0] P_LAST   = PW'(PRESC - 1);
    localparam logic [CW-1:0] D_LAST   = CW'(DWELL - 1);
    localparam logic [CW-1:0] G_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [1:0]    M_LAST   = 2'(NMODES - 1);
    localparam logic [2:0]    M_NUM    = 3'(NMODES);
    localparam bit            HAS_GAP  = (GAP > 0);

    state_t        state, state_n;
    logic [1:0]    mode_n;
    logic          en_n;
    logic [PW-1:0] presc, presc_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          restart;
    logic          sel_ok;
    logic [1:0]    mode_adv;

    assign tick     = (state != IDLE) && (presc == P_LAST);
    assign busy     = (state != IDLE);
    assign sel_ok   = ({1'b0, sel} < M_NUM);
    assign mode_adv = (mode == M_LAST) ? 2'd0 : mode + 2'd1;

    // Next state, mode and counters; restart clears timers on any transition
    always_comb begin
        state_n = state;
        mode_n  = mode;
        cnt_n   = cnt;
        restart = 1'b0;
        if (!run) begin
            state_n = IDLE;
            mode_n  = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    restart = 1'b1;
                    if (manual) begin
                        state_n = MAN;
                        mode_n  = sel_ok ? sel : 2'd0;
                    end else begin
                        state_n = PLAY;
                        mode_n  = 2'd0;
                    end
                end
                PLAY: begin
                    if (manual) begin
                        state_n = MAN;
                        restart = 1'b1;
                        if (sel_ok) mode_n = sel;
                    end else if (next || (tick && cnt == D_LAST)) begin
                        restart = 1'b1;
                        if (HAS_GAP) state_n = BLANK;
                        else         mode_n  = mode_adv;
                    end else if (tick) begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (manual) begin
                        state_n = MAN;
                        restart = 1'b1;
                        if (sel_ok) mode_n = sel;
                    end else if (tick && cnt == G_LAST) begin
                        state_n = PLAY;
                        mode_n  = mode_adv;
                        restart = 1'b1;
                    end else if (tick) begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                MAN: begin
                    if (!manual) begin
                        state_n = PLAY;
                        restart = 1'b1;
                    end else if (sel_ok) begin
                        mode_n = sel;
                    end
                end
                default: begin
                    state_n = IDLE;
                    mode_n  = 2'd0;
                end
            endcase
        end
        if (restart) cnt_n = '0;
        if (state_n == IDLE || restart)
            presc_n = '0;
        else if (presc == P_LAST)
            presc_n = '0;
        else
            presc_n = presc + 1'b1;
        en_n = (state_n == PLAY) || (state_n == MAN);
    end

    // State, outputs and timers registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mode  <= 2'd0;
            en    <= 1'b0;
            presc <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            mode  <= mode_n;
            en    <= en_n;
            presc <= presc_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_anim_sched.sv
// tb_anim_sched: scoreboard bench for anim_sched (default build and GAP=0).
// Expected {busy,en,mode,tick} per cycle are queued, then popped per cycle.
module tb_anim_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       run, manual, next;
    logic [1:0] sel;
    logic [1:0] mode;
    logic       en, tick, busy;

    logic       run_g, manual_g, next_g;
    logic [1:0] sel_g;
    logic [1:0] mode_g;
    logic       en_g, tick_g, busy_g;

    int total = 0;
    int bad   = 0;
    logic [4:0] exq[$];
    logic [4:0] want, got;

    always #5 clk = ~clk;

    anim_sched u_dut (
        .clk(clk), .rst(rst), .run(run), .manual(manual),
        .sel(sel), .next(next), .mode(mode), .en(en),
        .tick(tick), .busy(busy)
    );

    anim_sched #(.GAP(0)) u_g0 (
        .clk(clk), .rst(rst), .run(run_g), .manual(manual_g),
        .sel(sel_g), .next(next_g), .mode(mode_g), .en(en_g),
        .tick(tick_g), .busy(busy_g)
    );

    task automatic push_seg(input int n, input logic e, input logic [1:0] m);
        for (int j = 0; j < n; j++)
            exq.push_back({1'b1, e, m, ((j + 1) % 4 == 0)});
    endtask

    task automatic push_idle(input int n);
        for (int j = 0; j < n; j++) exq.push_back(5'b0);
    endtask

    task automatic test_reset;
        push_idle(20);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            want = exq.pop_front();
            got  = {busy, en, mode, tick};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%b want=%b", i, got, want);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_auto;
        push_seg(12, 1, 0); push_seg(8, 0, 0);
        push_seg(12, 1, 1); push_seg(8, 0, 1);
        push_seg(12, 1, 2); push_seg(8, 0, 2);
        push_seg(12, 1, 0); push_idle(2);
        run = 1'b1;
        for (int i = 1; i <= 74; i++) begin
            @(posedge clk); #1;
            want = exq.pop_front();
            got  = {busy, en, mode, tick};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL auto cyc=%0d got=%b want=%b", i, got, want);
            end
            if (i == 72) run = 1'b0;
        end
    endtask

    task automatic test_next;
        push_seg(12, 1, 0); push_seg(8, 0, 0);
        push_seg(5, 1, 1);  push_seg(8, 0, 1);
        push_seg(12, 1, 2); push_idle(1);
        run = 1'b1;
        for (int i = 1; i <= 46; i++) begin
            @(posedge clk); #1;
            want = exq.pop_front();
            got  = {busy, en, mode, tick};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL next cyc=%0d got=%b want=%b", i, got, want);
            end
            next = (i == 25) || (i == 27);
            if (i == 45) run = 1'b0;
        end
    endtask

    task automatic test_manual;
        push_seg(3, 1, 0);
        push_seg(4, 1, 2); push_seg(2, 1, 0);
        push_seg(12, 1, 0); push_seg(8, 0, 0);
        push_seg(1, 1, 1); push_idle(1);
        run = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            @(posedge clk); #1;
            want = exq.pop_front();
            got  = {busy, en, mode, tick};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL manual cyc=%0d got=%b want=%b", i, got, want);
            end
            if (i == 3) begin manual = 1'b1; sel = 2'd2; end
            if (i == 5) sel = 2'd3;
            if (i == 7) sel = 2'd0;
            if (i == 9) manual = 1'b0;
            if (i == 30) run = 1'b0;
        end
    endtask

    task automatic test_stop_reset;
        push_seg(12, 1, 0); push_seg(8, 0, 0);
        push_seg(12, 1, 1); push_seg(3, 0, 1);
        push_idle(3);       push_seg(5, 1, 0);
        run = 1'b1;
        for (int i = 1; i <= 43; i++) begin
            @(posedge clk); #1;
            want = exq.pop_front();
            got  = {busy, en, mode, tick};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL stop cyc=%0d got=%b want=%b", i, got, want);
            end
            if (i == 35) run = 1'b0;
            if (i == 38) run = 1'b1;
        end
        #2 rst = 1'b1;
        #1;
        got = {busy, en, mode, tick};
        total++;
        if (got !== 5'b0) begin
            bad++;
            $display("FAIL async_rst got=%b want=%b", got, 5'b0);
        end
        @(posedge clk); #1;
        got = {busy, en, mode, tick};
        total++;
        if (got !== 5'b0) begin
            bad++;
            $display("FAIL rst_hold got=%b want=%b", got, 5'b0);
        end
        run = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_gap0;
        push_seg(12, 1, 0); push_seg(12, 1, 1);
        push_seg(12, 1, 2); push_seg(4, 1, 0);
        push_seg(4, 1, 1);  push_idle(1);
        run_g = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk); #1;
            want = exq.pop_front();
            got  = {busy_g, en_g, mode_g, tick_g};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL gap0 cyc=%0d got=%b want=%b", i, got, want);
            end
            next_g = (i == 40);
            if (i == 44) run_g = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        run = 1'b0; manual = 1'b0; next = 1'b0; sel = 2'd0;
        run_g = 1'b0; manual_g = 1'b0; next_g = 1'b0; sel_g = 2'd0;
        #1;
        test_reset;
        test_auto;
        test_next;
        test_manual;
        test_stop_reset;
        test_gap0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
